// File: rtl/iomem_pkg.sv
// Shared constants for iomem-mapped peripherals: select-decode field
// positions and widths, GPIO register byte offsets, and a byte-strobe
// expander used by every register write.
package iomem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Peripheral select field iomem_addr[SEL_HI:SEL_LO]
  localparam int unsigned SEL_HI = 31;
  localparam int unsigned SEL_LO = 24;
  localparam int unsigned SEL_W  = SEL_HI - SEL_LO + 1;

  // Register word index iomem_addr[REG_HI:REG_LO]
  localparam int unsigned REG_HI = 7;
  localparam int unsigned REG_LO = 2;
  localparam int unsigned OFS_W  = REG_HI + 1;

  localparam logic [OFS_W-1:0] OFS_OUT    = 8'h00;
  localparam logic [OFS_W-1:0] OFS_OE     = 8'h04;
  localparam logic [OFS_W-1:0] OFS_IN     = 8'h08;
  localparam logic [OFS_W-1:0] OFS_STATUS = 8'h0C;
  localparam logic [OFS_W-1:0] OFS_MASK   = 8'h10;
  localparam logic [OFS_W-1:0] OFS_EDGE   = 8'h14;

  // Expand byte strobes into a per-bit write mask
  function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_W; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// N-bit multi-flop synchroniser for asynchronous pin inputs.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   i_d         - asynchronous input bits
//   o_q         - final synchroniser stage
// STAGES must be at least 2.
module gpio_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  // Shift chain: index 0 samples the pin, STAGES-1 is the output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/iomem_gpio.sv
// iomem-mapped GPIO block: output/enable registers, synchronised input
// readback and, with IOMEM_GPIO_IRQ_EN defined, an edge-triggered sticky
// STATUS register with mask, edge polarity select and level interrupt.
// Without IOMEM_GPIO_IRQ_EN, STATUS/MASK/EDGE read 0 and irq is tied low.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   iomem_valid/ready    - request and one-cycle completion pulse
//   iomem_wstrb          - byte write strobes (0 = read)
//   iomem_addr/wdata     - byte address and write data
//   iomem_rdata          - registered read data, held between accesses
//   gpio_in              - asynchronous pin inputs
//   gpio_out, gpio_oe    - pin output values and enables (1 = drive)
//   irq                  - level interrupt |(STATUS & MASK), registered
module iomem_gpio
  import iomem_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter logic [7:0]  BASE        = 8'h03,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  localparam int unsigned WARM_W = 3;
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic                r_ready;
  logic [DATA_W-1:0]   r_rdata;
  logic [WIDTH-1:0]    r_out;
  logic [WIDTH-1:0]    r_oe;

  logic                w_sel;
  logic                w_wr;
  logic [OFS_W-1:0]    w_ofs;
  logic [DATA_W-1:0]   w_mask32;
  logic [WIDTH-1:0]    w_wmask;
  logic [WIDTH-1:0]    w_wdata;
  logic [WIDTH-1:0]    w_sync;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused;

  // Byte-masked update of a WIDTH-bit register
  function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old_v,
                                               input logic [WIDTH-1:0] new_v,
                                               input logic [WIDTH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Access decode; ready high blocks a re-select so each access takes 2 cycles
  always_comb begin
    w_sel    = iomem_valid && !r_ready && (iomem_addr[SEL_HI:SEL_LO] == BASE);
    w_wr     = w_sel && (iomem_wstrb != 4'b0000);
    w_ofs    = {iomem_addr[REG_HI:REG_LO], 2'b00};
    w_mask32 = strb_mask(iomem_wstrb);
    w_wmask  = WIDTH'(w_mask32);
    w_wdata  = WIDTH'(iomem_wdata);
  end

  // Unused address/data bits are ignored by design
  assign w_unused = &{1'b0, iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, w_mask32};

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (gpio_in),
    .o_q   (w_sync)
  );

`ifdef IOMEM_GPIO_IRQ_EN
  logic [WIDTH-1:0]  r_status;
  logic [WIDTH-1:0]  r_mask;
  logic [WIDTH-1:0]  r_edge;
  logic [WIDTH-1:0]  r_prev;
  logic [WARM_W-1:0] r_warm;
  logic              r_irq;
  logic              w_armed;
  logic [WIDTH-1:0]  w_hit;
  logic [WIDTH-1:0]  w_clr;

  // Edge detect on raw synchronised samples only, so EDGE writes never fake an edge
  always_comb begin
    w_armed = (r_warm == WARM_DONE);
    w_hit   = '0;
    if (w_armed) begin
      w_hit = (r_edge & r_prev & ~w_sync) | (~r_edge & ~r_prev & w_sync);
    end
    w_clr = '0;
    if (w_wr && (w_ofs == OFS_STATUS)) begin
      w_clr = w_wdata & w_wmask;
    end
  end

  // Sticky status (set beats clear), interrupt controls and warm-up counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_status <= '0;
      r_mask   <= '0;
      r_edge   <= '0;
      r_prev   <= '0;
      r_warm   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_prev   <= w_sync;
      if (!w_armed) begin
        r_warm <= r_warm + WARM_W'(1);
      end
      r_status <= (r_status & ~w_clr) | w_hit;
      if (w_wr && (w_ofs == OFS_MASK)) begin
        r_mask <= f_merge(r_mask, w_wdata, w_wmask);
      end
      if (w_wr && (w_ofs == OFS_EDGE)) begin
        r_edge <= f_merge(r_edge, w_wdata, w_wmask);
      end
      r_irq    <= |(r_status & r_mask);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  // Read mux; unmapped offsets return 0
  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      OFS_OUT:    w_rdata = DATA_W'(r_out);
      OFS_OE:     w_rdata = DATA_W'(r_oe);
      OFS_IN:     w_rdata = DATA_W'(w_sync);
`ifdef IOMEM_GPIO_IRQ_EN
      OFS_STATUS: w_rdata = DATA_W'(r_status);
      OFS_MASK:   w_rdata = DATA_W'(r_mask);
      OFS_EDGE:   w_rdata = DATA_W'(r_edge);
`endif
      default:    w_rdata = '0;
    endcase
  end

  // Bus handshake, read data capture and pin control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
      r_out   <= '0;
      r_oe    <= '0;
    end else begin
      r_ready <= w_sel;
      if (w_sel) begin
        r_rdata <= w_rdata;
      end
      if (w_wr && (w_ofs == OFS_OUT)) begin
        r_out <= f_merge(r_out, w_wdata, w_wmask);
      end
      if (w_wr && (w_ofs == OFS_OE)) begin
        r_oe <= f_merge(r_oe, w_wdata, w_wmask);
      end
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign gpio_out    = r_out;
  assign gpio_oe     = r_oe;

endmodule

// File: tb/tb_iomem_gpio.sv
// Directed bench for iomem_gpio (WIDTH=8, BASE=8'h03, SYNC_STAGES=2):
// a table of bus accesses with expected handshake, read data and pin
// outputs, followed by hand-written multi-cycle sequences for input
// latency, reset abort and (when IOMEM_GPIO_IRQ_EN is defined) the edge
// detector and interrupt.
module tb_iomem_gpio;

  localparam logic [31:0] A_OUT    = 32'h0300_0000;
  localparam logic [31:0] A_OE     = 32'h0300_0004;
  localparam logic [31:0] A_IN     = 32'h0300_0008;
  localparam logic [31:0] A_STATUS = 32'h0300_000C;
  localparam logic [31:0] A_MASK   = 32'h0300_0010;
  localparam logic [31:0] A_EDGE   = 32'h0300_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        exp_rdy;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
    logic [7:0]  exp_oe;
  } vec_t;

  vec_t vecs[$];

  iomem_gpio #(
    .WIDTH       (8),
    .BASE        (8'h03),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                         input logic rdy, input logic [31:0] rd,
                         input logic [7:0] o, input logic [7:0] oe);
    vec_t v;
    v.addr = a; v.strb = s; v.wdata = d;
    v.exp_rdy = rdy; v.exp_rd = rd; v.exp_out = o; v.exp_oe = oe;
    vecs.push_back(v);
  endtask

  // One bus access: select edge, then the ready cycle, then one idle cycle
  task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic rdy, output logic [31:0] rd, output logic rdy_after);
    iomem_valid = 1'b1;
    iomem_addr  = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    @(negedge clk);
    rdy = iomem_ready;
    rd  = iomem_rdata;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    @(negedge clk);
    rdy_after = iomem_ready;
  endtask

  task automatic reg_write(input string name, input logic [31:0] a, input logic [31:0] d);
    logic rdy, rdy2;
    logic [31:0] rd;
    access(a, 4'b1111, d, rdy, rd, rdy2);
    check({name, " ready"}, 32'(rdy), 32'd1);
  endtask

  task automatic reg_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic rdy, rdy2;
    logic [31:0] rd;
    access(a, 4'b0000, 32'h0, rdy, rd, rdy2);
    check({name, " rdata"}, rd, exp);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic rdy, rdy2;
    logic [31:0] rd;

    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    gpio_in     = 8'h00;

    // addr, strb, wdata, exp ready, exp rdata, exp gpio_out, exp gpio_oe
    add_vec(A_OUT,         4'b0001, 32'h0000_00A5, 1'b1, 32'h0000_0000, 8'hA5, 8'h00);
    add_vec(A_OUT,         4'b0000, 32'h0,         1'b1, 32'h0000_00A5, 8'hA5, 8'h00);
    add_vec(A_OE,          4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 8'hA5, 8'hFF);
    add_vec(A_OE,          4'b0000, 32'h0,         1'b1, 32'h0000_00FF, 8'hA5, 8'hFF);
    add_vec(A_OUT,         4'b0010, 32'h0000_5A00, 1'b1, 32'h0000_00A5, 8'hA5, 8'hFF);
    add_vec(A_OUT,         4'b0001, 32'h0000_003C, 1'b1, 32'h0000_00A5, 8'h3C, 8'hFF);
    add_vec(32'h03AB_CD03, 4'b0000, 32'h0,         1'b1, 32'h0000_003C, 8'h3C, 8'hFF);
    add_vec(A_OE,          4'b0010, 32'h0000_0000, 1'b1, 32'h0000_00FF, 8'h3C, 8'hFF);
    add_vec(A_IN,          4'b1111, 32'h0000_00FF, 1'b1, 32'h0000_0000, 8'h3C, 8'hFF);
    add_vec(A_IN,          4'b0000, 32'h0,         1'b1, 32'h0000_0000, 8'h3C, 8'hFF);
    add_vec(32'h0300_0020, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 8'h3C, 8'hFF);
    add_vec(A_OUT,         4'b0000, 32'h0,         1'b1, 32'h0000_003C, 8'h3C, 8'hFF);
    add_vec(32'h0400_0000, 4'b1111, 32'h0000_00FF, 1'b0, 32'h0000_003C, 8'h3C, 8'hFF);
    add_vec(32'h0400_0004, 4'b1111, 32'h0000_0000, 1'b0, 32'h0000_003C, 8'h3C, 8'hFF);
    add_vec(32'h0300_0020, 4'b0000, 32'h0,         1'b1, 32'h0000_0000, 8'h3C, 8'hFF);
    add_vec(A_OE,          4'b0001, 32'h0000_005A, 1'b1, 32'h0000_00FF, 8'h3C, 8'h5A);
    add_vec(32'h03FF_FF07, 4'b0000, 32'h0,         1'b1, 32'h0000_005A, 8'h3C, 8'h5A);

    wait_cycles(3);
    check("reset ready", 32'(iomem_ready), 32'd0);
    check("reset rdata", iomem_rdata, 32'h0);
    check("reset gpio_out", 32'(gpio_out), 32'h0);
    check("reset gpio_oe", 32'(gpio_oe), 32'h0);
    check("reset irq", 32'(irq), 32'd0);
    reset = 1'b0;
    wait_cycles(2);

    // Table-driven register accesses
    foreach (vecs[i]) begin
      access(vecs[i].addr, vecs[i].strb, vecs[i].wdata, rdy, rd, rdy2);
      check($sformatf("vec%0d ready", i), 32'(rdy), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d ready_pulse_end", i), 32'(rdy2), 32'd0);
      check($sformatf("vec%0d gpio_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d gpio_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
    end

    // gpio_out changes right after the select edge of a write
    iomem_valid = 1'b1; iomem_addr = A_OUT; iomem_wstrb = 4'b0001; iomem_wdata = 32'h0000_0081;
    @(negedge clk);
    check("out_timing ready", 32'(iomem_ready), 32'd1);
    check("out_timing gpio_out", 32'(gpio_out), 32'h81);
    iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
    @(negedge clk);

    // Pin-to-IN latency is SYNC_STAGES+1: a read selected 2 edges after the change misses it
    gpio_in = 8'h80;
    @(negedge clk);
    reg_read("in_latency early", A_IN, 32'h0000_0000);
    reg_read("in_latency late", A_IN, 32'h0000_0080);

    // Reset during the select cycle aborts the write and the ready pulse
    reset = 1'b1;
    iomem_valid = 1'b1; iomem_addr = A_OUT; iomem_wstrb = 4'b0001; iomem_wdata = 32'h0000_0011;
    @(negedge clk);
    check("rst_abort ready", 32'(iomem_ready), 32'd0);
    check("rst_abort gpio_out", 32'(gpio_out), 32'h0);
    iomem_valid = 1'b0; iomem_wstrb = 4'b0000;
    gpio_in = 8'h81;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_abort no_late_ready", 32'(iomem_ready), 32'd0);
    wait_cycles(5);
    reg_read("after_rst OUT", A_OUT, 32'h0);
    reg_read("after_rst OE", A_OE, 32'h0);
    reg_read("after_rst STATUS", A_STATUS, 32'h0);
    reg_read("after_rst IN", A_IN, 32'h0000_0081);
    check("after_rst irq", 32'(irq), 32'd0);

`ifdef IOMEM_GPIO_IRQ_EN
    reg_write("edge0", A_EDGE, 32'h0);
    reg_write("mask08", A_MASK, 32'h0000_0008);
    reg_read("MASK readback", A_MASK, 32'h0000_0008);

    // Rising edge on pin 3: STATUS sets 3 edges after the change, irq one edge later
    gpio_in = 8'h89;
    wait_cycles(3);
    check("irq before status+1", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq asserted", 32'(irq), 32'd1);
    reg_read("STATUS rise", A_STATUS, 32'h0000_0008);
    reg_write("w1c", A_STATUS, 32'h0000_0008);
    check("irq cleared", 32'(irq), 32'd0);
    reg_read("STATUS cleared", A_STATUS, 32'h0);

    // Falling edge with EDGE=0 sets nothing; then W1C lands on the edge of a new rise
    gpio_in = 8'h81;
    wait_cycles(4);
    reg_read("STATUS fall ignored", A_STATUS, 32'h0);
    gpio_in = 8'h89;
    wait_cycles(2);
    reg_write("w1c collide", A_STATUS, 32'h0000_0008);
    reg_read("STATUS set wins", A_STATUS, 32'h0000_0008);
    check("irq set wins", 32'(irq), 32'd1);

    // EDGE write with the pin held high must not fake an edge
    reg_write("w1c again", A_STATUS, 32'h0000_00FF);
    reg_write("edge08", A_EDGE, 32'h0000_0008);
    wait_cycles(3);
    reg_read("STATUS no spurious", A_STATUS, 32'h0);
    reg_read("EDGE readback", A_EDGE, 32'h0000_0008);
    gpio_in = 8'h81;
    wait_cycles(5);
    reg_read("STATUS fall", A_STATUS, 32'h0000_0008);
    check("irq fall", 32'(irq), 32'd1);
`else
    reg_write("mask", A_MASK, 32'hFFFF_FFFF);
    reg_read("MASK absent", A_MASK, 32'h0);
    reg_write("edge", A_EDGE, 32'hFFFF_FFFF);
    reg_read("EDGE absent", A_EDGE, 32'h0);
    gpio_in = 8'h89;
    wait_cycles(5);
    reg_read("STATUS absent", A_STATUS, 32'h0);
    check("irq tied low", 32'(irq), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iomem_gpio.md
IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 8: number of GPIO pins, legal range 1..32.
- BASE, default 8'h03: value matched against iomem_addr[31:24].
- SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.

REQ-002 Ports SHALL be:
- clk          in   1      system clock.
- reset        in   1      synchronous, active-high reset.
- iomem_valid  in   1      bus request.
- iomem_ready  out  1      one-cycle completion pulse.
- iomem_wstrb  in   4      byte write strobes; 0 means read.
- iomem_addr   in   32     byte address.
- iomem_wdata  in   32     write data.
- iomem_rdata  out  32     read data.
- gpio_in      in   WIDTH  asynchronous pin inputs.
- gpio_out     out  WIDTH  pin output values.
- gpio_oe      out  WIDTH  pin output enables; 1 means drive.
- irq          out  1      level interrupt.

REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 Select condition: iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE.
REQ-005 When selected, iomem_ready SHALL be 1 on the next cycle for exactly one cycle; otherwise it SHALL be 0.
REQ-006 iomem_rdata SHALL be valid in the same cycle as iomem_ready and SHALL hold its value until the next selected access.
REQ-007 iomem_addr[7:2] SHALL select the register; iomem_addr[23:8] and [1:0] SHALL be ignored.
REQ-008 Register map (byte offset):
- 0x00 OUT: read/write, drives gpio_out.
- 0x04 OE: read/write, drives gpio_oe.
- 0x08 IN: read-only, synchronised pin values.
- 0x0C STATUS: sticky edge flags, write-1-to-clear.
- 0x10 MASK: read/write interrupt enables.
- 0x14 EDGE: read/write; per bit, 0 = rising edge, 1 = falling edge.
REQ-009 Writes SHALL honour each wstrb byte independently; a read SHALL return the pre-write value when wstrb is nonzero.
REQ-010 Bits at positions >= WIDTH SHALL read 0, and writes to them SHALL be ignored.
REQ-011 Unmapped offsets SHALL read 0, ignore writes, and still complete with ready.
REQ-012 Writes to IN SHALL be ignored.
REQ-013 gpio_in SHALL pass through SYNC_STAGES flops; IN SHALL read the final stage.
REQ-014 Latency from a pin change to a visible IN bit SHALL be SYNC_STAGES+1 cycles (the SYNC_STAGES synchroniser flops plus one cycle for the rdata register).
REQ-015 A one-cycle delayed copy of the final stage SHALL feed the edge detector; a bit SHALL set in STATUS on the selected edge.
REQ-016 If an edge set and a W1C clear hit the same STATUS bit in the same cycle, the set SHALL win.
REQ-017 A write to EDGE SHALL NOT generate spurious edges; detection SHALL compare only raw synchronised samples.
REQ-018 irq SHALL equal |(STATUS & MASK), registered, asserting 1 cycle after the STATUS bit sets.
REQ-019 Back-to-back accesses SHALL complete in 2 cycles each, since valid is ignored while ready is high.
REQ-020 gpio_out and gpio_oe SHALL update the cycle after the write's select cycle.

Reset
REQ-021 On reset the following SHALL clear to 0: OUT, OE (all pins input), STATUS, MASK, EDGE, iomem_ready, iomem_rdata, irq, synchroniser flops and the edge-history flops.
REQ-022 Reset asserted mid-access SHALL abort the access; no ready pulse SHALL follow and no register SHALL be written.
REQ-023 For the first SYNC_STAGES+1 cycles after reset release, the edge detector SHALL NOT set STATUS.

Configuration
REQ-024 Macro IOMEM_GPIO_IRQ_EN:
- Defined: STATUS, MASK, EDGE, the edge detector and irq SHALL be implemented as above.
- Undefined: those registers and that logic SHALL be absent; offsets 0x0C–0x14 SHALL read 0 and ignore writes; irq SHALL be tied to 0.

Structure
REQ-025 A shared package iomem_pkg SHALL hold the register offset constants (OFS_OUT, OFS_OE, OFS_IN, OFS_STATUS, OFS_MASK, OFS_EDGE) and the select-decode width constants.
REQ-026 One sub-module, gpio_sync (an N-bit, parametrised-depth synchroniser), SHALL be instantiated once.

Verification
REQ-027 Write OUT=0xA5 with wstrb=4'b0001, then read OUT -> rdata=0x000000A5, gpio_out=8'hA5 one cycle after the select cycle.
REQ-028 Write 32'hFFFF_FFFF to OE with wstrb=4'b1111, WIDTH=8 -> OE reads 0x000000FF.
REQ-029 Drive gpio_in[3] 0->1 with EDGE=0 and MASK=0x08 -> STATUS=0x08 and irq=1; write STATUS=0x08 -> STATUS=0x00 and irq=0 within 2 cycles.
REQ-030 Clear STATUS bit 3 in the same cycle a new rising edge on pin 3 is detected -> STATUS bit 3 remains 1.
REQ-031 Access an address with [31:24]=8'h04 -> no ready pulse and no register change; access offset 0x20 -> ready pulse with rdata=0.
REQ-032 Assert reset in the cycle after select -> no ready pulse, and OUT, OE and STATUS read 0 after release.
